// File: rtl/vga_sync_decoder_if.sv
// Sync-stream inputs and decoded raster outputs of vga_sync_decoder.
// ERR_COUNT is present only when VGA_SYNC_ERR_CNT_EN is defined.
interface vga_sync_decoder_if #(
  parameter int unsigned CNT_W = 11
) ();
  logic             H_SYNC;
  logic             V_SYNC;
  logic             LOCKED;
  logic             ACTIVE;
  logic [CNT_W-1:0] X_POS;
  logic [CNT_W-1:0] Y_POS;
  logic             FRAME_START;
  logic [CNT_W-1:0] H_TOTAL;
  logic [CNT_W-1:0] V_TOTAL;
`ifdef VGA_SYNC_ERR_CNT_EN
  logic [7:0]       ERR_COUNT;

  modport master (
    output H_SYNC, V_SYNC,
    input  LOCKED, ACTIVE, X_POS, Y_POS, FRAME_START, H_TOTAL, V_TOTAL, ERR_COUNT
  );
  modport slave (
    input  H_SYNC, V_SYNC,
    output LOCKED, ACTIVE, X_POS, Y_POS, FRAME_START, H_TOTAL, V_TOTAL, ERR_COUNT
  );
`else
  modport master (
    output H_SYNC, V_SYNC,
    input  LOCKED, ACTIVE, X_POS, Y_POS, FRAME_START, H_TOTAL, V_TOTAL
  );
  modport slave (
    input  H_SYNC, V_SYNC,
    output LOCKED, ACTIVE, X_POS, Y_POS, FRAME_START, H_TOTAL, V_TOTAL
  );
`endif
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: measures line/frame totals, locks, regenerates X/Y and data-enable.
// Optional lock-loss counter (ERR_COUNT) enabled by defining VGA_SYNC_ERR_CNT_EN.
module vga_sync_decoder #(
  parameter int unsigned H_SYNC_W     = 96,
  parameter int unsigned H_BACK_PORCH = 48,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned V_SYNC_W     = 2,
  parameter int unsigned V_BACK_PORCH = 33,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned LOCK_FRAMES  = 2,
  parameter int unsigned CNT_W        = 11
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  vga_sync_decoder_if.slave sync
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_VERIFY  = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_BEG   = CNT_W'(H_SYNC_W + H_BACK_PORCH);
  localparam logic [CNT_W:0]   H_END   = (CNT_W+1)'(H_SYNC_W + H_BACK_PORCH + H_VISIBLE);
  localparam logic [CNT_W-1:0] V_BEG   = CNT_W'(V_SYNC_W + V_BACK_PORCH);
  localparam logic [CNT_W:0]   V_END   = (CNT_W+1)'(V_SYNC_W + V_BACK_PORCH + V_VISIBLE);

  localparam int unsigned        MATCH_W    = $clog2(LOCK_FRAMES + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_FRAMES);

  logic               h_q, h_qq, v_q, v_qq;
  logic [CNT_W-1:0]   h_cnt, v_cnt;
  logic [1:0]         state, state_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt, match_inc;
  logic               h_known;
  logic [CNT_W-1:0]   h_total_q, v_total_q;
  logic               locked_q, active_q, frame_start_q;
  logic [CNT_W-1:0]   x_q, y_q;

  logic               h_edge, v_edge, h_sat, h_bad, v_bad, fail;
  logic               h_latch, v_latch, in_h, in_v, visible;
  logic [CNT_W-1:0]   line_len, frame_len;

  always_comb begin
    h_edge    = h_qq & ~h_q;
    v_edge    = v_qq & ~v_q;
    line_len  = h_cnt + 1'b1;
    frame_len = v_cnt + 1'b1;
    match_inc = match_cnt + 1'b1;

    h_sat   = (h_cnt == CNT_MAX) & ~h_edge;
    h_latch = h_edge & (state != ST_SEARCH) & ~h_known;
    v_latch = v_edge & (state == ST_MEASURE);
    // Line length is only compared once a reference has been latched in this lock attempt.
    h_bad   = h_edge & (state != ST_SEARCH) & h_known & (line_len != h_total_q);
    v_bad   = v_edge & ((state == ST_VERIFY) | (state == ST_LOCKED)) & (frame_len != v_total_q);
    fail    = h_sat | h_bad | v_bad;

    state_nxt = state;
    match_nxt = match_cnt;
    if (fail) begin
      state_nxt = ST_SEARCH;
    end else if (v_edge) begin
      case (state)
        ST_SEARCH:  state_nxt = ST_MEASURE;
        ST_MEASURE: begin
          state_nxt = ST_VERIFY;
          match_nxt = '0;
        end
        ST_VERIFY: begin
          match_nxt = match_inc;
          if (match_inc == MATCH_LAST) state_nxt = ST_LOCKED;
        end
        default:    state_nxt = ST_LOCKED;
      endcase
    end

    in_h    = (h_cnt >= H_BEG) && ({1'b0, h_cnt} < H_END);
    in_v    = (v_cnt >= V_BEG) && ({1'b0, v_cnt} < V_END);
    visible = locked_q & in_h & in_v;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_q           <= 1'b0;
      h_qq          <= 1'b0;
      v_q           <= 1'b0;
      v_qq          <= 1'b0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      state         <= ST_SEARCH;
      match_cnt     <= '0;
      h_known       <= 1'b0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      locked_q      <= 1'b0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      h_q  <= sync.H_SYNC;
      h_qq <= h_q;
      v_q  <= sync.V_SYNC;
      v_qq <= v_q;

      if (h_edge)                h_cnt <= '0;
      else if (h_cnt != CNT_MAX) h_cnt <= h_cnt + 1'b1;

      // A V edge coinciding with an H edge restarts the line count rather than advancing it.
      if (v_edge)                          v_cnt <= '0;
      else if (h_edge && v_cnt != CNT_MAX) v_cnt <= v_cnt + 1'b1;

      state     <= state_nxt;
      match_cnt <= match_nxt;

      if (state == ST_SEARCH) begin
        h_known <= 1'b0;
      end else if (h_latch) begin
        h_known   <= 1'b1;
        h_total_q <= line_len;
      end
      if (v_latch) v_total_q <= frame_len;

      locked_q      <= (state == ST_LOCKED);
      active_q      <= visible;
      x_q           <= visible ? (h_cnt - H_BEG) : '0;
      y_q           <= visible ? (v_cnt - V_BEG) : '0;
      frame_start_q <= v_edge & locked_q;
    end
  end

`ifdef VGA_SYNC_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_cnt <= '0;
    end else if ((state == ST_LOCKED) && (state_nxt == ST_SEARCH) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign sync.ERR_COUNT = err_cnt;
`endif

  assign sync.LOCKED      = locked_q;
  assign sync.ACTIVE      = active_q;
  assign sync.X_POS       = x_q;
  assign sync.Y_POS       = y_q;
  assign sync.FRAME_START = frame_start_q;
  assign sync.H_TOTAL     = h_total_q;
  assign sync.V_TOTAL     = v_total_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomized raster stimulus for vga_sync_decoder, checked cycle-by-cycle against a
// timestamp/stage-based reference model of the decoding rules.
module tb_vga_sync_decoder;
  localparam int HS  = 4;
  localparam int HBP = 3;
  localparam int HV  = 16;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int VV  = 6;
  localparam int LF  = 2;
  localparam int CW  = 8;
  localparam int MAXC = (1 << CW) - 1;
  localparam int HB  = HS + HBP;
  localparam int VB  = VS + VBP;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_sync_decoder_if #(.CNT_W(CW)) bus ();

  vga_sync_decoder #(
    .H_SYNC_W    (HS),
    .H_BACK_PORCH(HBP),
    .H_VISIBLE   (HV),
    .V_SYNC_W    (VS),
    .V_BACK_PORCH(VBP),
    .V_VISIBLE   (VV),
    .LOCK_FRAMES (LF),
    .CNT_W       (CW)
  ) dut (
    .CLOCK  (clk),
    .RESET_N(rst_n),
    .sync   (bus)
  );

  int unsigned n_vec, n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: counters are derived from edge timestamps; lock progress is a single
  // stage number (-2 searching, -1 measuring, 0..LF-1 verified frames, LF locked).
  int cyc, t_h, hcount, snap, stage, ht_m, vt_m, err_m;
  bit known, prev_ph, prev_pv, cur_locked;
  int exp_locked, exp_active, exp_x, exp_y, exp_fs, exp_ht, exp_vt, exp_err;
  int act_cnt, fs_cnt, last_x, last_y;

  task automatic model_reset();
    t_h = cyc - 1; snap = hcount; stage = -2; ht_m = 0; vt_m = 0; err_m = 0;
    known = 0; prev_ph = 0; prev_pv = 0; cur_locked = 0;
    exp_locked = 0; exp_active = 0; exp_x = 0; exp_y = 0; exp_fs = 0;
    exp_ht = 0; exp_vt = 0; exp_err = 0;
  endtask

  task automatic model_step();
    bit eh, ev, sat, fail, win;
    int hc, vc, len_l, len_f, nstage;
    if (!rst_n) begin
      model_reset();
    end else begin
      eh = prev_ph & ~bus.H_SYNC;
      ev = prev_pv & ~bus.V_SYNC;
      hc = cyc - t_h - 1;
      if (hc > MAXC) hc = MAXC;
      vc = hcount - snap;
      if (vc > MAXC) vc = MAXC;
      len_l = (hc + 1) & MAXC;
      len_f = (vc + 1) & MAXC;
      sat = (hc == MAXC) && !eh;

      win = cur_locked && hc >= HB && hc < HB + HV && vc >= VB && vc < VB + VV;
      exp_active = win ? 1 : 0;
      exp_x = win ? hc - HB : 0;
      exp_y = win ? vc - VB : 0;
      exp_fs = (ev && cur_locked) ? 1 : 0;
      exp_locked = (stage == LF) ? 1 : 0;

      fail = sat;
      if (eh && stage != -2 && known && len_l != ht_m) fail = 1;
      if (ev && stage >= 0 && len_f != vt_m) fail = 1;
      if (stage == -2) known = 0;
      else if (eh && !known) begin ht_m = len_l; known = 1; end
      if (ev && stage == -1) vt_m = len_f;

      nstage = stage;
      if (fail) nstage = -2;
      else if (ev) begin
        if (stage == -2) nstage = -1;
        else if (stage == -1) nstage = 0;
        else if (stage < LF) nstage = stage + 1;
      end
      if (stage == LF && nstage == -2 && err_m < 255) err_m++;
      stage = nstage;
      cur_locked = (exp_locked == 1);
      exp_ht = ht_m; exp_vt = vt_m; exp_err = err_m;

      if (eh) t_h = cyc;
      if (ev) snap = hcount + (eh ? 1 : 0);
      if (eh) hcount++;
      prev_ph = bus.H_SYNC;
      prev_pv = bus.V_SYNC;
    end
  endtask

  task automatic tick(input logic h, input logic v);
    @(negedge clk);
    cyc++;
    check_eq("locked",      32'(bus.LOCKED),      exp_locked);
    check_eq("active",      32'(bus.ACTIVE),      exp_active);
    check_eq("x_pos",       32'(bus.X_POS),       exp_x);
    check_eq("y_pos",       32'(bus.Y_POS),       exp_y);
    check_eq("frame_start", 32'(bus.FRAME_START), exp_fs);
    check_eq("h_total",     32'(bus.H_TOTAL),     exp_ht);
    check_eq("v_total",     32'(bus.V_TOTAL),     exp_vt);
`ifdef VGA_SYNC_ERR_CNT_EN
    check_eq("err_count",   32'(bus.ERR_COUNT),   exp_err);
`endif
    if (bus.ACTIVE) begin
      act_cnt++;
      last_x = int'(bus.X_POS);
      last_y = int'(bus.Y_POS);
    end
    if (bus.FRAME_START) fs_cnt++;
    model_step();
    bus.H_SYNC = h;
    bus.V_SYNC = v;
  endtask

  // Sync falls at pixel 0 of line 0, so V and H edges coincide; str_ln lengthens one line of
  // the first frame by a pixel; abort_px stops the last frame early.
  task automatic run_frames(input int ht, input int vt, input int nfr, input int str_ln,
                            input int abort_px);
    bit start_lock;
    int len, n;
    for (int f = 0; f < nfr; f++) begin
      act_cnt = 0; fs_cnt = 0; last_x = -1; last_y = -1; n = 0;
      start_lock = cur_locked;
      for (int ln = 0; ln < vt; ln++) begin
        len = ht + ((f == 0 && ln == str_ln) ? 1 : 0);
        for (int px = 0; px < len; px++) begin
          if (abort_px >= 0 && f == nfr - 1 && n == abort_px) return;
          tick((px >= HS) ? 1'b1 : 1'b0, (ln >= VS) ? 1'b1 : 1'b0);
          n++;
        end
      end
      if (start_lock && cur_locked) begin
        check_eq("active_per_frame", act_cnt, HV * VV);
        check_eq("fs_per_frame", fs_cnt, 1);
        check_eq("last_x", last_x, HV - 1);
        check_eq("last_y", last_y, VV - 1);
      end
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset_outs", 32'(|{bus.LOCKED, bus.ACTIVE, bus.FRAME_START, bus.X_POS,
                                          bus.Y_POS, bus.H_TOTAL, bus.V_TOTAL}), 0);
    model_reset();
    repeat (3) tick(1'b1, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    int ht, vt;
    n_vec = 0; n_err = 0; cyc = 0; hcount = 0;
    rst_n = 1'b0;
    bus.H_SYNC = 1'b1;
    bus.V_SYNC = 1'b1;
    model_reset();
    repeat (3) tick(1'b1, 1'b1);
    check_eq("reset_outs", 32'(|{bus.LOCKED, bus.ACTIVE, bus.FRAME_START, bus.X_POS,
                                 bus.Y_POS, bus.H_TOTAL, bus.V_TOTAL}), 0);
    rst_n = 1'b1;

    for (int it = 0; it < 2; it++) begin
      ht = 25 + int'($urandom_range(11, 0));
      vt = 11 + int'($urandom_range(3, 0));

      run_frames(ht, vt, 6, -1, -1);
      check_eq("lock_acquired", 32'(bus.LOCKED), 1);
      check_eq("h_total_raster", 32'(bus.H_TOTAL), ht);
      check_eq("v_total_raster", 32'(bus.V_TOTAL), vt);

      run_frames(ht, vt, 1, 1 + int'($urandom_range(vt - 3, 0)), -1);
      check_eq("stretch_unlock", 32'(bus.LOCKED), 0);
      check_eq("stretch_inactive", 32'(bus.ACTIVE), 0);
      run_frames(ht, vt, 5, -1, -1);
      check_eq("stretch_relock", 32'(bus.LOCKED), 1);

      run_frames(ht, vt + 1, 6, -1, -1);
      check_eq("taller_relock", 32'(bus.LOCKED), 1);
      check_eq("taller_v_total", 32'(bus.V_TOTAL), vt + 1);

      repeat (300) tick(1'b1, 1'b1);
      check_eq("hsat_unlock", 32'(bus.LOCKED), 0);
      check_eq("hsat_h_total_hold", 32'(bus.H_TOTAL), ht);

      run_frames(ht, vt, 6, -1, -1);
      check_eq("pre_reset_lock", 32'(bus.LOCKED), 1);
      run_frames(ht, vt, 1, -1, int'($urandom_range(ht * vt - 1, 0)));
      do_reset();
      run_frames(ht, vt, 6, -1, -1);
      check_eq("post_reset_relock", 32'(bus.LOCKED), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
